// File: rtl/matmul_host_sequencer_if.sv
// Bundle between the host sequencer and its neighbours: the word streams in and out
// plus the row-wide load/compute/unload port of matrix_multiplication.
interface matmul_host_sequencer_if #(
  parameter int DWIDTH = 16,
  parameter int N      = 16,
  parameter int AWIDTH = 7
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DWIDTH-1:0]     in_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DWIDTH-1:0]     out_data;
  logic                  out_last;

  logic                  enable_writing_to_mem;
  logic                  enable_reading_from_mem;
  logic [AWIDTH-1:0]     addr_pi;
  logic [N*DWIDTH-1:0]   data_pi;
  logic                  we_a;
  logic                  we_b;
  logic                  we_c;
  logic                  start_mat_mul;
  logic                  done_mat_mul;
  logic [N*DWIDTH-1:0]   data_from_out_mat;

  // The sequencer owns the matmul port and both stream ends it sources/sinks.
  modport master (
    input  in_valid, in_data, out_ready, done_mat_mul, data_from_out_mat,
    output in_ready, out_valid, out_data, out_last,
    output enable_writing_to_mem, enable_reading_from_mem, addr_pi, data_pi,
    output we_a, we_b, we_c, start_mat_mul
  );

  modport slave (
    output in_valid, in_data, out_ready, done_mat_mul, data_from_out_mat,
    input  in_ready, out_valid, out_data, out_last,
    input  enable_writing_to_mem, enable_reading_from_mem, addr_pi, data_pi,
    input  we_a, we_b, we_c, start_mat_mul
  );
endinterface

// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer for matrix_multiplication: packs words into A/B rows, runs the
// compute handshake, then reads C rows back and serializes them as a word stream.
module matmul_host_sequencer #(
  parameter int DWIDTH = 16,
  parameter int N      = 16,
  parameter int AWIDTH = 7,
  parameter int ROWS   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_go,
  output logic o_busy,
  matmul_host_sequencer_if.master bus
);

  localparam int WCW = (N > 1) ? $clog2(N) : 1;
  localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [WCW-1:0] LastWord = WCW'(N - 1);
  localparam logic [RCW-1:0] LastRow  = RCW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    WDRAIN,
    COMPUTE,
    CDRAIN,
    READ_C
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [WCW-1:0]      r_wordCnt;
  logic [RCW-1:0]      r_rowCnt;
  logic [N*DWIDTH-1:0] r_pack;
  logic [N*DWIDTH-1:0] r_hold;
  logic [N*DWIDTH-1:0] r_shift;
  logic [N*DWIDTH-1:0] w_packNext;
  logic [AWIDTH-1:0]   r_addr;
  logic                r_wrStrobe;
  logic                r_wrIsB;
  logic                r_wrStrobeD1;
  logic                r_wrIsBD1;
  logic                r_wrStrobeD2;
  logic                r_wrIsBD2;
  logic [1:0]          r_drainCnt;
  logic [1:0]          r_rdWait;
  logic                r_outValid;
  logic [WCW-1:0]      r_outCnt;

  logic w_inReady;
  logic w_inAccept;
  logic w_rowDone;
  logic w_matDone;
  logic w_outAccept;
  logic w_outLast;

  assign w_inReady   = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_inAccept  = w_inReady && bus.in_valid;
  assign w_rowDone   = w_inAccept && (r_wordCnt == LastWord);
  assign w_matDone   = w_rowDone && (r_rowCnt == LastRow);
  assign w_outAccept = r_outValid && bus.out_ready;
  assign w_outLast   = r_outValid && (r_outCnt == LastWord) && (r_rowCnt == LastRow);

  always_comb begin
    w_packNext = r_pack;
    w_packNext[r_wordCnt*DWIDTH +: DWIDTH] = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_go) w_nextState = LOAD_A;
      LOAD_A:  if (w_matDone) w_nextState = LOAD_B;
      LOAD_B:  if (w_matDone) w_nextState = WDRAIN;
      WDRAIN:  if (r_drainCnt == 2'd2) w_nextState = COMPUTE;
      COMPUTE: if (bus.done_mat_mul) w_nextState = CDRAIN;
      CDRAIN:  w_nextState = READ_C;
      READ_C:  if (w_outLast && bus.out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Row packing, write issue and C unload share the row counter and address register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wordCnt  <= '0;
      r_rowCnt   <= '0;
      r_pack     <= '0;
      r_hold     <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_wrStrobe <= 1'b0;
      r_wrIsB    <= 1'b0;
      r_drainCnt <= '0;
      r_rdWait   <= '0;
      r_outValid <= 1'b0;
      r_outCnt   <= '0;
    end else begin
      r_wrStrobe <= 1'b0;
      r_drainCnt <= (r_state == WDRAIN) ? r_drainCnt + 1'b1 : 2'd0;
      case (r_state)
        IDLE: begin
          r_wordCnt <= '0;
          r_rowCnt  <= '0;
        end
        LOAD_A, LOAD_B: begin
          if (w_inAccept) begin
            r_pack <= w_packNext;
            if (r_wordCnt == LastWord) begin
              r_wordCnt  <= '0;
              r_hold     <= w_packNext;
              r_addr     <= AWIDTH'(r_rowCnt);
              r_wrStrobe <= 1'b1;
              r_wrIsB    <= (r_state == LOAD_B);
              r_rowCnt   <= (r_rowCnt == LastRow) ? '0 : r_rowCnt + 1'b1;
            end else begin
              r_wordCnt <= r_wordCnt + 1'b1;
            end
          end
        end
        CDRAIN: begin
          r_addr     <= '0;
          r_rowCnt   <= '0;
          r_rdWait   <= '0;
          r_outValid <= 1'b0;
          r_outCnt   <= '0;
        end
        READ_C: begin
          // C RAM answers three cycles after the address; sample on the fourth.
          if (!r_outValid) begin
            if (r_rdWait == 2'd3) begin
              r_shift    <= bus.data_from_out_mat;
              r_outValid <= 1'b1;
              r_outCnt   <= '0;
            end else begin
              r_rdWait <= r_rdWait + 1'b1;
            end
          end else if (w_outAccept) begin
            r_shift <= r_shift >> DWIDTH;
            if (r_outCnt == LastWord) begin
              r_outValid <= 1'b0;
              r_outCnt   <= '0;
              r_rdWait   <= '0;
              if (r_rowCnt != LastRow) begin
                r_rowCnt <= r_rowCnt + 1'b1;
                r_addr   <= AWIDTH'(r_rowCnt + 1'b1);
              end else begin
                r_rowCnt <= '0;
              end
            end else begin
              r_outCnt <= r_outCnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The matmul registers its address twice before the RAM, so the enables follow suit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrStrobeD1 <= 1'b0;
      r_wrIsBD1    <= 1'b0;
      r_wrStrobeD2 <= 1'b0;
      r_wrIsBD2    <= 1'b0;
    end else begin
      r_wrStrobeD1 <= r_wrStrobe;
      r_wrIsBD1    <= r_wrIsB;
      r_wrStrobeD2 <= r_wrStrobeD1;
      r_wrIsBD2    <= r_wrIsBD1;
    end
  end

  assign o_busy                      = (r_state != IDLE);
  assign bus.in_ready                = w_inReady;
  assign bus.out_valid               = r_outValid;
  assign bus.out_data                = r_shift[DWIDTH-1:0];
  assign bus.out_last                = w_outLast;
  assign bus.enable_writing_to_mem   = w_inReady || (r_state == WDRAIN);
  assign bus.enable_reading_from_mem = (r_state == READ_C);
  assign bus.addr_pi                 = r_addr;
  assign bus.data_pi                 = r_hold;
  assign bus.we_a                    = r_wrStrobeD2 && !r_wrIsBD2;
  assign bus.we_b                    = r_wrStrobeD2 && r_wrIsBD2;
  assign bus.we_c                    = (r_state == COMPUTE);
  assign bus.start_mat_mul           = (r_state == COMPUTE);

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Directed bench for matmul_host_sequencer with a small behavioural matmul on the far side.
module tb_matmul_host_sequencer;

  logic clk;
  logic reset;
  logic go;
  logic busy;

  matmul_host_sequencer_if #(.DWIDTH(16), .N(16), .AWIDTH(7)) bus ();

  matmul_host_sequencer #(.DWIDTH(16), .N(16), .AWIDTH(7), .ROWS(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_go   (go),
    .o_busy (busy),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [255:0] expA [16];
  logic [255:0] expB [16];
  logic [255:0] expC [16];
  logic [255:0] memA [16];
  logic [255:0] memB [16];
  logic [255:0] memC [16];
  logic [6:0]   wa1, wa2, ra1, ra2, ra3;
  int           doneDelay = 5;
  int           computeCycles = 0;

  int           weACount, weBCount, startCycles;
  logic [6:0]   addrD1, addrD2, addrD3;
  logic [15:0]  outWords [$];
  logic         outLastQ [$];
  logic         stallPrev, lastPrev, heldLast;
  logic [15:0]  heldData;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      passCount++;
  endtask

  function automatic logic [255:0] computeRow(input int i);
    logic [255:0] row;
    logic [15:0]  acc;
    row = '0;
    for (int j = 0; j < 16; j++) begin
      acc = '0;
      for (int k = 0; k < 16; k++)
        acc = acc + 16'(memA[i][k*16 +: 16] * memB[k][j*16 +: 16]);
      row[j*16 +: 16] = acc;
    end
    return row;
  endfunction

  // Behavioural matmul: two-stage write address pipe, three-cycle C read latency.
  assign bus.done_mat_mul      = bus.start_mat_mul && (computeCycles >= doneDelay);
  assign bus.data_from_out_mat = memC[ra3[3:0]];

  always @(posedge clk) begin
    wa1 <= bus.addr_pi;
    wa2 <= wa1;
    ra1 <= bus.addr_pi;
    ra2 <= ra1;
    ra3 <= ra2;
    computeCycles <= bus.start_mat_mul ? computeCycles + 1 : 0;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        memA[i] <= '0;
        memB[i] <= '0;
        memC[i] <= '0;
      end
    end else begin
      if (bus.we_a) memA[wa2[3:0]] <= bus.data_pi;
      if (bus.we_b) memB[wa2[3:0]] <= bus.data_pi;
      if (bus.start_mat_mul && bus.done_mat_mul)
        for (int i = 0; i < 16; i++) memC[i] <= computeRow(i);
    end
  end

  // Write-pulse monitor: each pulse must trail its row address by exactly two cycles.
  always @(negedge clk) begin
    if (reset) begin
      weACount    <= 0;
      weBCount    <= 0;
      startCycles <= 0;
    end else begin
      if (bus.we_a && bus.we_b) checkOutput("we_overlap", 1, 0);
      if (bus.we_a) begin
        checkOutput("weA_addr", addrD2, weACount);
        if (weACount != 0) checkOutput("weA_prev_addr", addrD3, weACount - 1);
        checkOutput("weA_row", bus.data_pi, expA[weACount]);
        checkOutput("weA_before_B", weBCount, 0);
        weACount <= weACount + 1;
      end
      if (bus.we_b) begin
        checkOutput("weB_addr", addrD2, weBCount);
        checkOutput("weB_prev_addr", addrD3, (weBCount == 0) ? 15 : weBCount - 1);
        checkOutput("weB_row", bus.data_pi, expB[weBCount]);
        checkOutput("weB_after_A", weACount, 16);
        weBCount <= weBCount + 1;
      end
      if (bus.start_mat_mul) startCycles <= startCycles + 1;
    end
    addrD1 <= bus.addr_pi;
    addrD2 <= addrD1;
    addrD3 <= addrD2;
  end

  // Output collector with hold-under-backpressure and busy-after-last checks.
  always @(negedge clk) begin
    if (reset) begin
      outWords.delete();
      outLastQ.delete();
    end else begin
      if (stallPrev) begin
        checkOutput("hold_valid", bus.out_valid, 1);
        checkOutput("hold_data", bus.out_data, heldData);
        checkOutput("hold_last", bus.out_last, heldLast);
      end
      if (lastPrev) checkOutput("busy_after_last", busy, 0);
      if (bus.out_valid && bus.out_ready) begin
        outWords.push_back(bus.out_data);
        outLastQ.push_back(bus.out_last);
      end
    end
    stallPrev <= !reset && bus.out_valid && !bus.out_ready;
    lastPrev  <= !reset && bus.out_valid && bus.out_ready && bus.out_last;
    heldData  <= bus.out_data;
    heldLast  <= bus.out_last;
  end

  task automatic setPattern(input int sel);
    logic [15:0] a;
    for (int r = 0; r < 16; r++) begin
      expA[r] = '0;
      expB[r] = '0;
      expC[r] = '0;
      for (int c = 0; c < 16; c++) begin
        a = (sel == 0) ? 16'(r*16 + c) : 16'(16'h1000 + r*16 + c);
        expA[r][c*16 +: 16] = a;
        expC[r][c*16 +: 16] = (sel == 0) ? a : 16'(a * 2);
      end
      expB[r][r*16 +: 16] = (sel == 0) ? 16'd1 : 16'd2;
    end
  endtask

  task automatic checkIdleOutputs();
    checkOutput("idle_ctrl", {bus.in_ready, bus.out_valid, bus.out_data, bus.out_last,
                              bus.enable_writing_to_mem, bus.enable_reading_from_mem, bus.addr_pi,
                              bus.we_a, bus.we_b, bus.we_c, bus.start_mat_mul, busy}, 0);
    checkOutput("idle_data_pi", bus.data_pi, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    go = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkIdleOutputs();
    reset = 1'b0;
  endtask

  task automatic pushWord(input logic [15:0] w, input bit gaps);
    int g;
    int guard;
    g = 0;
    while (gaps && ($urandom_range(1, 0) == 0) && g < 8) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("in_ready_timeout", guard, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic loadRows(input bit isB, input int nRows, input bit gaps);
    for (int r = 0; r < nRows; r++)
      for (int c = 0; c < 16; c++)
        pushWord(isB ? expB[r][c*16 +: 16] : expA[r][c*16 +: 16], gaps);
  endtask

  task automatic applyStimulus(input bit gaps, input int stallAt, input bit goDuringRead);
    int guard;
    int lastCount;
    bit stalled;
    bit goSent;
    bus.out_ready = 1'b1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    loadRows(1'b0, 16, gaps);
    loadRows(1'b1, 16, gaps);
    guard = 0;
    stalled = 1'b0;
    goSent = 1'b0;
    while (outWords.size() < 256 && guard < 5000) begin
      if (stallAt >= 0 && !stalled && outWords.size() >= stallAt) begin
        stalled = 1'b1;
        bus.out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
      end
      if (goDuringRead && !goSent && outWords.size() >= 1) begin
        goSent = 1'b1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) checkOutput("out_timeout", outWords.size(), 256);
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("out_count", outWords.size(), 256);
    for (int i = 0; i < 256; i++)
      checkOutput("out_word", outWords[i], expC[i/16][(i%16)*16 +: 16]);
    lastCount = 0;
    foreach (outLastQ[i]) if (outLastQ[i]) lastCount++;
    checkOutput("out_last_count", lastCount, 1);
    checkOutput("out_last_pos", outLastQ[255], 1);
    checkOutput("weA_count", weACount, 16);
    checkOutput("weB_count", weBCount, 16);
    for (int r = 0; r < 16; r++) begin
      checkOutput("memA_row", memA[r], expA[r]);
      checkOutput("memB_row", memB[r], expB[r]);
    end
    checkOutput("busy_idle", busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    go = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    $display("[TB] reset state and basic transaction");
    doReset();
    setPattern(0);
    doneDelay = 5;
    applyStimulus(1'b0, -1, 1'b0);
    checkOutput("start_cycles_delay5", startCycles, 6);

    $display("[TB] input backpressure");
    doReset();
    applyStimulus(1'b1, -1, 1'b0);

    $display("[TB] output backpressure");
    doReset();
    applyStimulus(1'b0, 37, 1'b0);

    $display("[TB] done in first compute cycle, go during READ_C");
    doReset();
    doneDelay = 0;
    applyStimulus(1'b0, -1, 1'b1);
    checkOutput("start_cycles_first", startCycles, 1);

    $display("[TB] reset during LOAD_B, then full transaction");
    doReset();
    setPattern(1);
    doneDelay = 2;
    bus.out_ready = 1'b1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    loadRows(1'b0, 16, 1'b0);
    loadRows(1'b1, 6, 1'b0);
    checkOutput("busy_in_loadB", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkIdleOutputs();
    reset = 1'b0;
    applyStimulus(1'b0, -1, 1'b0);
    checkOutput("start_cycles_delay2", startCycles, 3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
